// File: rtl/plab3_mem_cache_pkg.sv
// ----------------------------------------------------------------------------
// plab3_mem_cache_pkg: shared encodings and geometry helpers for the N-way cache
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package plab3_mem_cache_pkg;

   localparam logic [2:0] TYPE_READ  = 3'd0;
   localparam logic [2:0] TYPE_WRITE = 3'd1;
   localparam logic [2:0] TYPE_INIT  = 3'd2;

   localparam int LINE_BYTES = 16;

   typedef enum logic [3:0] {
      ST_IDLE          = 4'd0,
      ST_TAG_CHECK     = 4'd1,
      ST_INIT_ACCESS   = 4'd2,
      ST_READ_ACCESS   = 4'd3,
      ST_WRITE_ACCESS  = 4'd4,
      ST_EVICT_PREP    = 4'd5,
      ST_EVICT_REQ     = 4'd6,
      ST_EVICT_WAIT    = 4'd7,
      ST_REFILL_REQ    = 4'd8,
      ST_REFILL_WAIT   = 4'd9,
      ST_REFILL_UPDATE = 4'd10,
      ST_RESP          = 4'd11
   } state_t;

   function automatic int cache_idxw(input int mem_nbytes, input int num_ways);
      return $clog2(mem_nbytes / (LINE_BYTES * num_ways));
   endfunction

   function automatic int cache_tagw(input int mem_nbytes, input int num_ways);
      return 28 - cache_idxw(mem_nbytes, num_ways);
   endfunction

endpackage

`default_nettype wire

// File: rtl/plab3_mem_cache_way.sv
// ----------------------------------------------------------------------------
// plab3_mem_cache_way: one way's tag/valid/dirty arrays and 128-bit line storage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plab3_mem_cache_way #(
   parameter int NSETS = 8,
   parameter int IDXW  = 3,
   parameter int TAGW  = 25
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [IDXW-1:0] index,
   input  logic [TAGW-1:0] tag,
   input  logic            data_wen,
   input  logic [15:0]     byte_en,
   input  logic [127:0]    wdata,
   input  logic            meta_wen,
   input  logic            meta_dirty,
   output logic            match,
   output logic            valid,
   output logic            dirty,
   output logic [TAGW-1:0] rd_tag,
   output logic [127:0]    rdata
);

   logic [TAGW-1:0]  tags  [NSETS];
   logic [127:0]     lines [NSETS];
   logic [NSETS-1:0] valids;
   logic [NSETS-1:0] dirtys;

   always_ff @(posedge clk) begin
      if (reset) begin
         valids <= '0;
         dirtys <= '0;
      end else if (meta_wen) begin
         valids[index] <= 1'b1;
         dirtys[index] <= meta_dirty;
      end
   end

   // Tag and data storage are deliberately left uninitialised; valid gates them.
   always_ff @(posedge clk) begin
      if (meta_wen)
         tags[index] <= tag;
      if (data_wen) begin
         for (int b = 0; b < 16; b++) begin
            if (byte_en[b])
               lines[index][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign valid  = valids[index];
   assign dirty  = dirtys[index];
   assign rd_tag = tags[index];
   assign rdata  = lines[index];
   assign match  = valid && (tags[index] == tag);

endmodule

`default_nettype wire

// File: rtl/plab3_mem_blocking_cache_nway.sv
// ----------------------------------------------------------------------------
// plab3_mem_blocking_cache_nway: N-way write-back write-allocate blocking cache
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plab3_mem_blocking_cache_nway
   import plab3_mem_cache_pkg::*;
#(
   parameter int p_mem_nbytes   = 256,
   parameter int p_num_ways     = 2,
   parameter int p_opaque_nbits = 8
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [68+p_opaque_nbits:0]  cachereq_msg,
   input  logic                        cachereq_val,
   output logic                        cachereq_rdy,
   output logic [36+p_opaque_nbits:0]  cacheresp_msg,
   output logic                        cacheresp_val,
   input  logic                        cacheresp_rdy,
   output logic [166+p_opaque_nbits:0] memreq_msg,
   output logic                        memreq_val,
   input  logic                        memreq_rdy,
   input  logic [134+p_opaque_nbits:0] memresp_msg,
   input  logic                        memresp_val,
   output logic                        memresp_rdy
);

   localparam int OW    = p_opaque_nbits;
   localparam int NSETS = p_mem_nbytes / (LINE_BYTES * p_num_ways);
   localparam int IDXW  = cache_idxw(p_mem_nbytes, p_num_ways);
   localparam int IDXA  = (IDXW > 0) ? IDXW : 1;
   localparam int TAGW  = cache_tagw(p_mem_nbytes, p_num_ways);
   localparam int WAYW  = (p_num_ways > 1) ? $clog2(p_num_ways) : 1;

   state_t state, state_next;

   logic [2:0]      r_type;
   logic [OW-1:0]   r_opaque;
   logic [31:0]     r_addr;
   logic [1:0]      r_len;
   logic [31:0]     r_data;
   logic [WAYW-1:0] r_way;
   logic            r_alloc;
   logic [127:0]    r_line;
   logic [TAGW-1:0] r_vtag;
   logic [31:0]     r_rdata;
   logic [WAYW-1:0] rr [NSETS];

   logic [IDXA-1:0]       idx;
   logic [TAGW-1:0]       req_tag;
   logic [p_num_ways-1:0] way_match, way_valid, way_dirty;
   logic [p_num_ways-1:0] data_wen, meta_wen;
   logic [TAGW-1:0]       way_tag  [p_num_ways];
   logic [127:0]          way_data [p_num_ways];
   logic                  hit;
   logic [WAYW-1:0]       hit_way, victim;
   logic [15:0]           byte_en, word_be;
   logic [127:0]          wdata;
   logic                  meta_dirty;
   logic [31:0]           sel_word, shifted, rd_word;
   logic                  unused_memresp;

   assign unused_memresp = ^memresp_msg[134+OW:128];

   if (IDXW > 0) begin : g_idx_on
      assign idx = r_addr[4 +: IDXA];
   end else begin : g_idx_off
      assign idx = '0;
   end

   assign req_tag = r_addr[31 -: TAGW];

   for (genvar w = 0; w < p_num_ways; w++) begin : g_way
      plab3_mem_cache_way #(
         .NSETS (NSETS),
         .IDXW  (IDXA),
         .TAGW  (TAGW)
      ) u_way (
         .clk        (clk),
         .reset      (reset),
         .index      (idx),
         .tag        (req_tag),
         .data_wen   (data_wen[w]),
         .byte_en    (byte_en),
         .wdata      (wdata),
         .meta_wen   (meta_wen[w]),
         .meta_dirty (meta_dirty),
         .match      (way_match[w]),
         .valid      (way_valid[w]),
         .dirty      (way_dirty[w]),
         .rd_tag     (way_tag[w]),
         .rdata      (way_data[w])
      );
   end

   // Lowest-index invalid way wins over the round-robin pointer.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      victim  = rr[idx];
      for (int w = 0; w < p_num_ways; w++) begin
         if (way_match[w]) begin
            hit     = 1'b1;
            hit_way = WAYW'(w);
         end
      end
      for (int w = p_num_ways - 1; w >= 0; w--) begin
         if (!way_valid[w])
            victim = WAYW'(w);
      end
   end

   always_comb begin
      sel_word = way_data[r_way][{r_addr[3:2], 5'b00000} +: 32];
      shifted  = sel_word >> {r_addr[1:0], 3'b000};
      case (r_len)
         2'd1:    rd_word = {24'h0, shifted[7:0]};
         2'd2:    rd_word = {16'h0, shifted[15:0]};
         default: rd_word = shifted;
      endcase
   end

   assign word_be = 16'h000F << {r_addr[3:2], 2'b00};

   always_comb begin
      byte_en    = '0;
      wdata      = {4{r_data}};
      data_wen   = '0;
      meta_wen   = '0;
      meta_dirty = 1'b0;
      if (!reset) begin
         case (state)
            ST_REFILL_UPDATE: begin
               byte_en         = '1;
               wdata           = r_line;
               data_wen[r_way] = 1'b1;
               meta_wen[r_way] = 1'b1;
            end
            ST_INIT_ACCESS: begin
               byte_en         = word_be;
               data_wen[r_way] = 1'b1;
               meta_wen[r_way] = 1'b1;
            end
            ST_WRITE_ACCESS: begin
               case (r_len)
                  2'd1: begin
                     byte_en = 16'h0001 << r_addr[3:0];
                     wdata   = {16{r_data[7:0]}};
                  end
                  2'd2: begin
                     byte_en = 16'h0003 << r_addr[3:0];
                     wdata   = {8{r_data[15:0]}};
                  end
                  default: byte_en = word_be;
               endcase
               data_wen[r_way] = 1'b1;
               meta_wen[r_way] = 1'b1;
               meta_dirty      = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:          if (cachereq_val) state_next = ST_TAG_CHECK;
         ST_TAG_CHECK: begin
            if (r_type == TYPE_INIT)
               state_next = ST_INIT_ACCESS;
            else if (hit)
               state_next = (r_type == TYPE_WRITE) ? ST_WRITE_ACCESS : ST_READ_ACCESS;
            else if (way_valid[victim] && way_dirty[victim])
               state_next = ST_EVICT_PREP;
            else
               state_next = ST_REFILL_REQ;
         end
         ST_INIT_ACCESS:   state_next = ST_RESP;
         ST_READ_ACCESS:   state_next = ST_RESP;
         ST_WRITE_ACCESS:  state_next = ST_RESP;
         ST_EVICT_PREP:    state_next = ST_EVICT_REQ;
         ST_EVICT_REQ:     if (memreq_rdy) state_next = ST_EVICT_WAIT;
         ST_EVICT_WAIT:    if (memresp_val) state_next = ST_REFILL_REQ;
         ST_REFILL_REQ:    if (memreq_rdy) state_next = ST_REFILL_WAIT;
         ST_REFILL_WAIT:   if (memresp_val) state_next = ST_REFILL_UPDATE;
         ST_REFILL_UPDATE: state_next = (r_type == TYPE_WRITE) ? ST_WRITE_ACCESS : ST_READ_ACCESS;
         ST_RESP:          if (cacheresp_rdy) state_next = ST_IDLE;
         default:          state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < NSETS; s++)
            rr[s] <= '0;
      end else if ((state == ST_REFILL_UPDATE) || (state == ST_INIT_ACCESS && r_alloc)) begin
         rr[idx] <= (rr[idx] == WAYW'(p_num_ways - 1)) ? '0 : rr[idx] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_IDLE && cachereq_val) begin
         r_type   <= cachereq_msg[66+OW +: 3];
         r_opaque <= cachereq_msg[66 +: OW];
         r_addr   <= cachereq_msg[34 +: 32];
         r_len    <= cachereq_msg[32 +: 2];
         r_data   <= cachereq_msg[31:0];
      end
      if (state == ST_TAG_CHECK) begin
         r_way   <= hit ? hit_way : victim;
         r_alloc <= !hit;
      end
      if (state == ST_EVICT_PREP) begin
         r_line <= way_data[r_way];
         r_vtag <= way_tag[r_way];
      end
      if (state == ST_REFILL_WAIT && memresp_val)
         r_line <= memresp_msg[127:0];
      if (state == ST_READ_ACCESS)
         r_rdata <= rd_word;
      if (state == ST_INIT_ACCESS || state == ST_WRITE_ACCESS)
         r_rdata <= '0;
   end

   assign cachereq_rdy  = (state == ST_IDLE);
   assign cacheresp_val = (state == ST_RESP);
   assign cacheresp_msg = {r_type, r_opaque, r_len, r_rdata};
   assign memresp_rdy   = (state == ST_EVICT_WAIT) || (state == ST_REFILL_WAIT);
   assign memreq_val    = (state == ST_EVICT_REQ) || (state == ST_REFILL_REQ);

   always_comb begin
      if (state == ST_EVICT_REQ)
         memreq_msg = {TYPE_WRITE, {OW{1'b0}}, {r_vtag, r_addr[IDXW+3:0]} & ~32'hF, 4'h0, r_line};
      else
         memreq_msg = {TYPE_READ, {OW{1'b0}}, {r_addr[31:4], 4'h0}, 4'h0, 128'h0};
   end

endmodule

`default_nettype wire

// File: tb/tb_plab3_mem_blocking_cache_nway.sv
// ----------------------------------------------------------------------------
// tb_plab3_mem_blocking_cache_nway: directed self-checking bench with a memory model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_plab3_mem_blocking_cache_nway;

   localparam logic [2:0] RD = 3'd0;
   localparam logic [2:0] WR = 3'd1;
   localparam logic [2:0] IN = 3'd2;

   logic         clk = 1'b0;
   logic         reset;
   logic [76:0]  cachereq_msg;
   logic         cachereq_val;
   logic         cachereq_rdy;
   logic [44:0]  cacheresp_msg;
   logic         cacheresp_val;
   logic         cacheresp_rdy;
   logic [174:0] memreq_msg;
   logic         memreq_val;
   logic         memreq_rdy;
   logic [142:0] memresp_msg;
   logic         memresp_val;
   logic         memresp_rdy;

   int total = 0;
   int bad   = 0;

   int           mem_lat   = 2;
   logic         mem_stall = 1'b0;
   int           flush_req = 0;
   int           flush_seen;
   int           rd_cnt, wr_cnt;
   logic [31:0]  last_rd_addr, last_wr_addr;
   logic [127:0] last_wr_data;
   logic [127:0] mem [1024];

   plab3_mem_blocking_cache_nway dut (
      .clk           (clk),
      .reset         (reset),
      .cachereq_msg  (cachereq_msg),
      .cachereq_val  (cachereq_val),
      .cachereq_rdy  (cachereq_rdy),
      .cacheresp_msg (cacheresp_msg),
      .cacheresp_val (cacheresp_val),
      .cacheresp_rdy (cacheresp_rdy),
      .memreq_msg    (memreq_msg),
      .memreq_val    (memreq_val),
      .memreq_rdy    (memreq_rdy),
      .memresp_msg   (memresp_msg),
      .memresp_val   (memresp_val),
      .memresp_rdy   (memresp_rdy)
   );

   always #5 clk = ~clk;

   // Line memory: decisions taken at negedge apply to the following posedge.
   initial begin : mem_model
      logic [174:0] cap;
      logic [31:0]  a;
      logic         req_hs, resp_hs, pend;
      int           delay;
      logic [127:0] pdata;
      logic [2:0]   ptype;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[10'h200] = 128'h01020304;
      rd_cnt = 0; wr_cnt = 0; flush_seen = 0;
      last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
      memreq_rdy = 1'b1; memresp_val = 1'b0; memresp_msg = '0;
      req_hs = 0; resp_hs = 0; pend = 0; delay = 0; pdata = '0; ptype = '0; cap = '0;
      forever begin
         @(negedge clk);
         if (resp_hs || flush_req != flush_seen) begin
            memresp_val = 1'b0;
            pend = 1'b0;
         end
         flush_seen = flush_req;
         if (req_hs) begin
            ptype = cap[174:172];
            a     = cap[163:132];
            if (ptype == WR) begin
               mem[a[13:4]] = cap[127:0];
               wr_cnt++;
               last_wr_addr = a;
               last_wr_data = cap[127:0];
               pdata = '0;
            end else begin
               rd_cnt++;
               last_rd_addr = a;
               pdata = mem[a[13:4]];
            end
            pend  = 1'b1;
            delay = mem_lat;
         end
         if (pend && !memresp_val) begin
            if (delay <= 0) begin
               memresp_val = 1'b1;
               memresp_msg = {ptype, 8'h00, 4'h0, pdata};
            end else begin
               delay--;
            end
         end
         memreq_rdy = !mem_stall;
         req_hs     = memreq_val && memreq_rdy;
         cap        = memreq_msg;
         resp_hs    = memresp_val && memresp_rdy;
      end
   end

   task automatic chk(input string tag, input logic [179:0] obs, input logic [179:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bound_chk(input string tag, input int n, input int lim);
      total++;
      assert (n < lim) else begin
         bad++;
         $error("FAIL %s timeout observed=%0d expected<%0d", tag, n, lim);
      end
   endtask

   task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                       input logic [1:0] l, input logic [31:0] d);
      int n;
      @(negedge clk);
      cachereq_msg = {t, op, a, l, d};
      cachereq_val = 1'b1;
      n = 0;
      while (!cachereq_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      bound_chk("req_accept", n, 50);
      @(negedge clk);
      cachereq_val = 1'b0;
   endtask

   task automatic get_resp(input string tag, input logic [2:0] t, input logic [7:0] op,
                           input logic [1:0] l, input logic [31:0] d);
      int n;
      n = 0;
      while (!cacheresp_val && n < 200) begin
         @(negedge clk);
         n++;
      end
      bound_chk({tag, "_wait"}, n, 200);
      chk(tag, cacheresp_msg, {t, op, l, d});
      @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int n, base_rd, base_wr;
      logic [174:0] exp_req;
      logic [44:0]  exp_resp;
      reset = 1'b1; cachereq_val = 1'b0; cachereq_msg = '0; cacheresp_rdy = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_cachereq_rdy", cachereq_rdy, 1);
      chk("rst_cacheresp_val", cacheresp_val, 0);
      chk("rst_memreq_val", memreq_val, 0);
      chk("rst_memresp_rdy", memresp_rdy, 0);

      // Init then read hit: response in the 3rd cycle after acceptance.
      base_rd = rd_cnt; base_wr = wr_cnt;
      send(IN, 8'h11, 32'h1000, 2'd0, 32'hdeadbeef);
      get_resp("init_resp", IN, 8'h11, 2'd0, 32'h0);
      send(RD, 8'h12, 32'h1000, 2'd0, 32'h0);
      chk("hit_lat_c1", cacheresp_val, 0);
      @(negedge clk);
      chk("hit_lat_c2", cacheresp_val, 0);
      @(negedge clk);
      chk("hit_lat_c3", cacheresp_val, 1);
      get_resp("hit_read", RD, 8'h12, 2'd0, 32'hdeadbeef);

      // Subword writes and reads on the resident line.
      send(WR, 8'h21, 32'h1001, 2'd1, 32'h000000ab);
      get_resp("wr_byte_resp", WR, 8'h21, 2'd1, 32'h0);
      send(RD, 8'h22, 32'h1000, 2'd0, 32'h0);
      get_resp("rd_after_byte", RD, 8'h22, 2'd0, 32'hdeadabef);
      send(RD, 8'h23, 32'h1003, 2'd1, 32'h0);
      get_resp("rd_byte3", RD, 8'h23, 2'd1, 32'h000000de);
      send(WR, 8'h24, 32'h1002, 2'd2, 32'h00001234);
      get_resp("wr_half_resp", WR, 8'h24, 2'd2, 32'h0);
      send(RD, 8'h25, 32'h1002, 2'd2, 32'h0);
      get_resp("rd_half", RD, 8'h25, 2'd2, 32'h00001234);
      send(RD, 8'h26, 32'h1000, 2'd0, 32'h0);
      get_resp("rd_after_half", RD, 8'h26, 2'd0, 32'h1234abef);
      chk("hits_no_memreq", (rd_cnt - base_rd) + (wr_cnt - base_wr), 0);

      // Clean miss into the free way, with response backpressure.
      base_rd = rd_cnt; base_wr = wr_cnt;
      cacheresp_rdy = 1'b0;
      send(RD, 8'h31, 32'h2000, 2'd0, 32'h0);
      n = 0;
      while (!cacheresp_val && n < 100) begin @(negedge clk); n++; end
      bound_chk("clean_miss_wait", n, 100);
      exp_resp = {RD, 8'h31, 2'd0, 32'h01020304};
      chk("clean_miss_data", cacheresp_msg, exp_resp);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("resp_backpressure", {cacheresp_val, cacheresp_msg, cachereq_rdy}, {1'b1, exp_resp, 1'b0});
      end
      cacheresp_rdy = 1'b1;
      @(negedge clk);
      chk("resp_release", {cacheresp_val, cachereq_rdy}, 2'b01);
      chk("clean_miss_counts", {rd_cnt - base_rd, wr_cnt - base_wr}, {32'd1, 32'd0});
      chk("clean_miss_addr", last_rd_addr, 32'h2000);

      // Dirty eviction in set 0.
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      send(WR, 8'h41, 32'h0000, 2'd0, 32'h00000011);
      get_resp("wr_0000", WR, 8'h41, 2'd0, 32'h0);
      send(WR, 8'h42, 32'h0080, 2'd0, 32'h00000022);
      get_resp("wr_0080", WR, 8'h42, 2'd0, 32'h0);
      base_rd = rd_cnt; base_wr = wr_cnt;
      mem_stall = 1'b1;
      send(RD, 8'h43, 32'h0100, 2'd0, 32'h0);
      n = 0;
      while (!memreq_val && n < 50) begin @(negedge clk); n++; end
      bound_chk("evict_req_wait", n, 50);
      exp_req = {WR, 8'h00, 32'h0000_0000, 4'h0, 128'h11};
      chk("evict_req_msg", memreq_msg, exp_req);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("memreq_stall_hold", {memreq_val, memreq_msg, cachereq_rdy}, {1'b1, exp_req, 1'b0});
      end
      mem_stall = 1'b0;
      get_resp("evict_read", RD, 8'h43, 2'd0, 32'h0);
      chk("evict_counts", {rd_cnt - base_rd, wr_cnt - base_wr}, {32'd1, 32'd1});
      chk("evict_refill_addr", last_rd_addr, 32'h0100);
      base_rd = rd_cnt; base_wr = wr_cnt;
      send(RD, 8'h44, 32'h0000, 2'd0, 32'h0);
      get_resp("reread_0000", RD, 8'h44, 2'd0, 32'h00000011);
      chk("reread_evict", {last_wr_addr, last_wr_data}, {32'h0080, 128'h22});
      chk("reread_counts", {rd_cnt - base_rd, wr_cnt - base_wr}, {32'd1, 32'd1});

      // Reset while waiting for a refill.
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      mem_lat = 8;
      send(RD, 8'h51, 32'h2000, 2'd0, 32'h0);
      n = 0;
      while (!memresp_rdy && n < 50) begin @(negedge clk); n++; end
      bound_chk("refill_wait_reach", n, 50);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_outputs", {cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy}, 4'b1000);
      n = 0;
      while (!memresp_val && n < 50) begin @(negedge clk); n++; end
      bound_chk("late_resp_wait", n, 50);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_resp_refused", {memresp_val, memresp_rdy, cacheresp_val}, 3'b100);
      end
      flush_req++;
      n = 0;
      while (memresp_val && n < 20) begin @(negedge clk); n++; end
      bound_chk("flush_wait", n, 20);
      mem_lat = 1;
      base_rd = rd_cnt;
      send(RD, 8'h52, 32'h2000, 2'd0, 32'h0);
      get_resp("post_reset_read", RD, 8'h52, 2'd0, 32'h01020304);
      chk("post_reset_miss", rd_cnt - base_rd, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
